mac_proc_core: RTL

//  Parametrised next-generation matrix-multiply processor core: multi-cycle fetch/execute engine with a

---
 rtl/mac_proc_pkg.sv | 37 +++
 rtl/mac_proc_if.sv | 27 ++
 rtl/mac_proc_regfile.sv | 35 +++
 rtl/mac_proc_core.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mac_proc_pkg.sv
// rtl/mac_proc_pkg.sv - opcodes, FSM states and instruction field slices for mac_proc_core
package mac_proc_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_LDAR  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_MAC   = 4'h4;
  localparam logic [3:0] OP_CLRAC = 4'h5;
  localparam logic [3:0] OP_INCAR = 4'h6;
  localparam logic [3:0] OP_ADDAR = 4'h7;
  localparam logic [3:0] OP_DEC   = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_STAC  = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // A 4-bit register field can name 16 slots regardless of NREG
  localparam int REG_SLOTS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

endpackage

// File: rtl/mac_proc_if.sv
// rtl/mac_proc_if.sv - instruction and data memory req/ack bus for mac_proc_core
interface mac_proc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int PC_W   = 8
);
  logic              im_req;
  logic [PC_W-1:0]   im_addr;
  logic [15:0]       im_rdata;
  logic              im_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  modport master (
    output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  im_rdata, im_ack, dm_rdata, dm_ack
  );

  modport slave (
    input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output im_rdata, im_ack, dm_rdata, dm_ack
  );
endinterface

// File: rtl/mac_proc_regfile.sv
// rtl/mac_proc_regfile.sv - NREG x DATA_W register file, two async reads, one write
module mac_proc_regfile
  import mac_proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_ra_addr,
  input  logic [3:0]        i_rb_addr,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic              i_we,
  input  logic [3:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  // Slots at or above NREG are never written, so they read back as 0
  logic [DATA_W-1:0] r_regs [REG_SLOTS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < REG_SLOTS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < NREG; i++) begin
        if (i_wa == 4'(i)) r_regs[i] <= i_wd;
      end
    end
  end

  assign o_ra_data = r_regs[i_ra_addr];
  assign o_rb_data = r_regs[i_rb_addr];

endmodule

// File: rtl/mac_proc_core.sv
// rtl/mac_proc_core.sv - fetch/execute MAC processor core; MAC_SATURATE_EN selects saturating MAC/STAC
module mac_proc_core
  import mac_proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 16,
  parameter int PC_W   = 8,
  parameter int NREG   = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  mac_proc_if.master       bus,
  output logic             busy,
  output logic             end_process,
  output logic [ACC_W-1:0] ac_out
);

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [ADDR_W-1:0] r_ar;
  logic [ACC_W-1:0]  r_ac;
  logic [15:0]       r_ir;
  logic              r_z;
  logic              r_im_req;
  logic              r_dm_req;
  logic              r_dm_we;
  logic [DATA_W-1:0] r_dm_wdata;
  logic              r_busy;
  logic              r_end;

  logic [3:0]          w_op;
  logic [3:0]          w_ra;
  logic [3:0]          w_rb;
  logic [7:0]          w_imm;
  logic [DATA_W-1:0]   w_ra_data;
  logic [DATA_W-1:0]   w_rb_data;
  logic [DATA_W-1:0]   w_dec;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_mac;
  logic [DATA_W-1:0]   w_stac;
  logic                w_rf_we;
  logic [DATA_W-1:0]   w_rf_wd;

  assign w_op  = r_ir[OP_MSB:OP_LSB];
  assign w_ra  = r_ir[RA_MSB:RA_LSB];
  assign w_rb  = r_ir[RB_MSB:RB_LSB];
  assign w_imm = r_ir[IMM_MSB:IMM_LSB];

  mac_proc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .i_clk     (clock),
    .i_rst     (rst),
    .i_ra_addr (w_ra),
    .i_rb_addr (w_rb),
    .o_ra_data (w_ra_data),
    .o_rb_data (w_rb_data),
    .i_we      (w_rf_we),
    .i_wa      (w_ra),
    .i_wd      (w_rf_wd)
  );

  assign w_dec  = w_ra_data - DATA_W'(1);
  assign w_prod = {{DATA_W{1'b0}}, w_ra_data} * {{DATA_W{1'b0}}, w_rb_data};

`ifdef MAC_SATURATE_EN
  logic [ACC_W:0] w_sum;
  assign w_sum  = {1'b0, r_ac} + (ACC_W+1)'(w_prod);
  assign w_mac  = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_stac = (|r_ac[ACC_W-1:DATA_W]) ? '1 : r_ac[DATA_W-1:0];
`else
  assign w_mac  = r_ac + ACC_W'(w_prod);
  assign w_stac = r_ac[DATA_W-1:0];
`endif

  always_comb begin
    w_rf_we = 1'b0;
    w_rf_wd = '0;
    if (r_state == S_EXEC && w_op == OP_LDI) begin
      w_rf_we = 1'b1;
      w_rf_wd = DATA_W'(w_imm);
    end else if (r_state == S_EXEC && w_op == OP_DEC) begin
      w_rf_we = 1'b1;
      w_rf_wd = w_dec;
    end else if (r_state == S_MEM && !r_dm_we && bus.dm_ack) begin
      w_rf_we = 1'b1;
      w_rf_wd = bus.dm_rdata;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ar       <= '0;
      r_ac       <= '0;
      r_ir       <= '0;
      r_z        <= 1'b0;
      r_im_req   <= 1'b0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_wdata <= '0;
      r_busy     <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state  <= S_FETCH;
          r_im_req <= 1'b1;
          r_busy   <= 1'b1;
        end
        S_FETCH: if (bus.im_ack) begin
          r_ir     <= bus.im_rdata;
          r_pc     <= r_pc + PC_W'(1);
          r_im_req <= 1'b0;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          // Default: straight back to fetch; memory ops and HALT override below
          r_state  <= S_FETCH;
          r_im_req <= 1'b1;
          case (w_op)
            OP_LDAR:  r_ar <= ADDR_W'(w_ra_data);
            OP_MAC:   r_ac <= w_mac;
            OP_CLRAC: r_ac <= '0;
            OP_INCAR: r_ar <= r_ar + ADDR_W'(1);
            OP_ADDAR: r_ar <= r_ar + ADDR_W'(w_imm);
            OP_DEC:   r_z  <= (w_dec == '0);
            OP_JNZ:   if (!r_z) r_pc <= PC_W'(w_imm);
            OP_LOAD: begin
              r_im_req <= 1'b0;
              r_dm_req <= 1'b1;
              r_dm_we  <= 1'b0;
              r_state  <= S_MEM;
            end
            OP_STAC: begin
              r_im_req   <= 1'b0;
              r_dm_req   <= 1'b1;
              r_dm_we    <= 1'b1;
              r_dm_wdata <= w_stac;
              r_state    <= S_MEM;
            end
            OP_HALT: begin
              r_im_req <= 1'b0;
              r_busy   <= 1'b0;
              r_end    <= 1'b1;
              r_state  <= S_HALT;
            end
            default: ;
          endcase
        end
        S_MEM: if (bus.dm_ack) begin
          r_dm_req <= 1'b0;
          r_dm_we  <= 1'b0;
          r_im_req <= 1'b1;
          r_state  <= S_FETCH;
        end
        S_HALT:  ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.im_req   = r_im_req;
  assign bus.im_addr  = r_pc;
  assign bus.dm_req   = r_dm_req;
  assign bus.dm_we    = r_dm_we;
  assign bus.dm_addr  = r_ar;
  assign bus.dm_wdata = r_dm_wdata;
  assign busy         = r_busy;
  assign end_process  = r_end;
  assign ac_out       = r_ac;

endmodule
